// File: rtl/stoch_to_bin_if.sv
// Result channel of stoch_to_bin: decoded count with a valid/ready handshake.
// The producer drives out/valid through the master modport, and the consumer drives ready.
interface stoch_to_bin_if #(
    parameter int W = 8
) ();
    logic [W:0] out;
    logic       valid;
    logic       ready;

    modport master (
        output out,
        output valid,
        input  ready
    );

    modport slave (
        input  out,
        input  valid,
        output ready
    );
endinterface

// File: rtl/stoch_to_bin.sv
// stoch_to_bin: counts the ones of a stochastic bitstream over 2^W enabled samples.
// Defining STOCH_TO_BIN_RESCALE_EN loads min(count * SCALE_N, 2^W) instead of the raw count.
module stoch_to_bin #(
    parameter int W       = 8,
    parameter int SCALE_N = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           start,
    input  logic           in,
    output logic           busy,
    stoch_to_bin_if.master res
);
    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    localparam logic [W:0] LAST_IDX = {1'b0, {W{1'b1}}};
    localparam logic [W:0] FULL     = {1'b1, {W{1'b0}}};
    localparam logic [W:0] ONE      = {{W{1'b0}}, 1'b1};

    state_t     state;
    logic [W:0] sample_cnt;
    logic [W:0] ones_cnt;
    logic [W:0] final_cnt;
    logic [W:0] result;

    if (SCALE_N < 1) begin : g_scale_check
        $error("stoch_to_bin: SCALE_N must be at least 1");
    end

    // Count including the sample taken on the current edge.
    assign final_cnt = ones_cnt + {{W{1'b0}}, in};

`ifdef STOCH_TO_BIN_RESCALE_EN
    localparam int PW = $clog2(SCALE_N * (2 ** W) + 1);

    logic [PW-1:0] product;

    always_comb begin
        product = PW'(final_cnt) * PW'(SCALE_N);
        result  = (product > PW'(FULL)) ? FULL : product[W:0];
    end
`else
    assign result = final_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            ones_cnt   <= '0;
            res.out    <= '0;
            res.valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COUNT;
                        sample_cnt <= '0;
                        ones_cnt   <= '0;
                        busy       <= 1'b1;
                    end
                end
                COUNT: begin
                    if (en) begin
                        sample_cnt <= sample_cnt + ONE;
                        ones_cnt   <= final_cnt;
                        if (sample_cnt == LAST_IDX) begin
                            state     <= HOLD;
                            res.out   <= result;
                            res.valid <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // A transfer with START set doubles as the start of the next window.
                    if (res.ready) begin
                        res.valid <= 1'b0;
                        if (start) begin
                            state      <= COUNT;
                            sample_cnt <= '0;
                            ones_cnt   <= '0;
                            busy       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
